mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Sequences the MEM stage behind the EX/MEM pipeline latch. Takes memread/memwrite/branch/zero,
//  alu_result and rdata2out from the latch. Runs a req/ack handshake with a variable-latency data
//  memory, stalls the upstream pipeline until the access completes, and resolves branches (PCSrc/flush).
//  Sits between the EX/MEM latch, data memory, the MEM/WB latch and the hazard/PC logic.
// PARAMETERS
//  MAX_WAIT  15  max REQ cycles without dmem_ack before timeout (>=1)
//  CNT_W     16  width of stall_cycles counter
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      synchronous active-low reset
//  memread      in   1      load in EX/MEM
//  memwrite     in   1      store in EX/MEM
//  branch       in   1      branch in EX/MEM
//  zero         in   1      ALU zero flag from EX/MEM
//  alu_result   in   32     effective address
//  rdata2out    in   32     store data
//  dmem_req     out  1      memory request, held until ack
//  dmem_we      out  1      1=write, 0=read
//  dmem_addr    out  32     memory address
//  dmem_wdata   out  32     memory write data
//  dmem_ack     in   1      memory completion, 1-cycle pulse
//  dmem_rdata   in   32     read data, valid with dmem_ack
//  read_data    out  32     load result to MEM/WB latch
//  stall        out  1      freeze PC, IF/ID, ID/EX, EX/MEM
//  pcsrc        out  1      take branch target
//  flush        out  1      squash IF/ID, ID/EX
//  mem_err      out  1      sticky timeout flag
//  stall_cycles out  CNT_W  stall cycle count (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//   - state=IDLE; dmem_req, dmem_we, dmem_addr, dmem_wdata, read_data, mem_err, wait_cnt, stall_cycles=0.
//   - Reset mid-access aborts the access; dmem_req is 0 after that edge.
//  FSM states: IDLE, REQ, DONE, ERR.
//   - IDLE: memread|memwrite -> REQ. Register dmem_addr=alu_result, dmem_wdata=rdata2out,
//     dmem_we=memwrite, dmem_req=1, wait_cnt=0. Both memread and memwrite set is treated as a write.
//   - REQ: addr/wdata/we are held stable. dmem_ack -> DONE, dmem_req=0; on a read,
//     read_data<=dmem_rdata. No ack with wait_cnt==MAX_WAIT-1 -> ERR, dmem_req=0.
//     Otherwise wait_cnt++.
//   - DONE: one cycle, then -> IDLE. The pipeline advances on this edge; read_data stays valid.
//   - ERR: one cycle. read_data<=32'hDEADBEEF, mem_err<=1 (sticky until reset). Then -> IDLE.
//   - dmem_ack outside REQ is ignored.
//  stall (combinational):
//   - stall = (IDLE & (memread|memwrite)) | REQ. Deasserted in DONE and ERR.
//   - Latency: ack in the k-th REQ cycle gives k+1 stall cycles (minimum 2). Timeout gives MAX_WAIT+1.
//  Branch (combinational):
//   - pcsrc = branch & zero & ~stall.
//   - flush = pcsrc.
//   - Branch and memory access in the same slot: the branch resolves only once stall drops.
//  No zero-latency path: a new access is accepted in IDLE only, never directly from DONE.
// CONFIGURATION
//  MEM_STALL_CNT_EN defined:
//   - stall_cycles increments on every posedge with stall=1, saturating at all-ones.
//   - Cleared only by reset.
//  MEM_STALL_CNT_EN undefined:
//   - stall_cycles is tied to 0 and no counter logic is synthesised.
// TESTING
//  1 Reset: rst_n=0 for 2 clk, random inputs -> every output 0, stall=0.
//  2 Load: memread=1, alu_result=0x40, ack in 3rd REQ cycle with rdata=0x12345678 ->
//    dmem_req=1 for 3 cycles, dmem_addr=0x40, dmem_we=0, stall=1 for 4 cycles, read_data=0x12345678 in DONE.
//  3 Store: memwrite=1, alu_result=0x80, rdata2out=0xCAFEF00D, ack in 1st REQ cycle ->
//    dmem_we=1, dmem_wdata=0xCAFEF00D, stall=1 for exactly 2 cycles.
//  4 Timeout: MAX_WAIT=15, memread=1, never ack -> dmem_req high 15 cycles, then
//    read_data=0xDEADBEEF, mem_err=1, and mem_err stays 1 through later good accesses.
//  5 Branch: branch=1, zero=1, no access -> pcsrc=1, flush=1 same cycle. zero=0 -> both 0.
//    branch=1, zero=1, memread=1 -> pcsrc=0 until DONE.
//  6 Reset in 2nd REQ cycle -> dmem_req=0 next edge, IDLE. With MEM_STALL_CNT_EN, test 2 then
//    test 3 -> stall_cycles=6.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage sequencer behind the EX/MEM latch.
// Issues one req/ack transaction per load/store to a variable-latency data
// memory. It stalls the upstream pipeline while the access is in flight and
// resolves branches once the stage is no longer stalled.
// Optional feature: define MEM_STALL_CNT_EN to build the saturating
// stall_cycles counter. Without it, stall_cycles is tied to zero.

module mem_access_ctrl #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             memread,
  input  logic             memwrite,
  input  logic             branch,
  input  logic             zero,
  input  logic [31:0]      alu_result,
  input  logic [31:0]      rdata2out,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [31:0]      dmem_addr,
  output logic [31:0]      dmem_wdata,
  input  logic             dmem_ack,
  input  logic [31:0]      dmem_rdata,
  output logic [31:0]      read_data,
  output logic             stall,
  output logic             pcsrc,
  output logic             flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  logic [1:0]        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              access;

  assign access = memread | memwrite;

  // Access sequencer. It latches the request in IDLE, waits for the ack in
  // REQ, and spends one cycle in DONE or ERR before accepting new work.
  // The timeout poison value and the error flag are written on entry to ERR.
  // This way they are already in place when the pipeline advances out of ERR.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      read_data  <= '0;
      mem_err    <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            state      <= REQ;
            dmem_addr  <= alu_result;
            dmem_wdata <= rdata2out;
            dmem_we    <= memwrite;
            dmem_req   <= 1'b1;
            wait_cnt   <= '0;
          end
        end
        REQ: begin
          if (dmem_ack) begin
            state    <= DONE;
            dmem_req <= 1'b0;
            if (!dmem_we) begin
              read_data <= dmem_rdata;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            state     <= ERR;
            dmem_req  <= 1'b0;
            read_data <= 32'hDEADBEEF;
            mem_err   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        ERR: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Hold the upstream stages whenever an access is pending or in flight.
  always_comb begin
    stall = ((state == IDLE) && access) || (state == REQ);
  end

  // A branch only resolves in a slot that is not stalled.
  always_comb begin
    pcsrc = branch & zero & ~stall;
    flush = pcsrc;
  end

`ifdef MEM_STALL_CNT_EN
  // Count stalled edges, saturating at all-ones. Only reset clears the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed, self-checking bench for mem_access_ctrl.
// The driver walks a transaction-level timeline and publishes the expected
// outputs for each cycle. A negedge process compares the DUT against them.
// Literal checks after each scenario pin the cycle counts and data values.

module tb_mem_access_ctrl;

  localparam int MAX_WAIT = 15;
  localparam int CNT_W    = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             memread, memwrite, branch, zero;
  logic [31:0]      alu_result, rdata2out;
  logic             dmem_req, dmem_we;
  logic [31:0]      dmem_addr, dmem_wdata;
  logic             dmem_ack;
  logic [31:0]      dmem_rdata;
  logic [31:0]      read_data;
  logic             stall, pcsrc, flush, mem_err;
  logic [CNT_W-1:0] stall_cycles;

  int n_tests = 0;
  int n_fail  = 0;

  logic             chk_en = 1'b0;
  logic             chk_bus = 1'b0;
  logic             chk_rd = 1'b0;
  logic             exp_req = 1'b0, exp_stall = 1'b0, exp_pcsrc = 1'b0, exp_we = 1'b0;
  logic [31:0]      exp_addr = '0, exp_wdata = '0, exp_rd = '0;
  logic             exp_err = 1'b0;
  logic [CNT_W-1:0] exp_sc = '0;

  int obs_req = 0, obs_stall = 0, obs_pcsrc = 0, obs_flush = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .memread(memread), .memwrite(memwrite),
    .branch(branch), .zero(zero), .alu_result(alu_result), .rdata2out(rdata2out),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .read_data(read_data), .stall(stall), .pcsrc(pcsrc), .flush(flush),
    .mem_err(mem_err), .stall_cycles(stall_cycles)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setBubble();
    memread   = 1'b0;
    memwrite  = 1'b0;
    branch    = 1'b0;
    zero      = 1'b0;
    dmem_ack  = 1'b0;
    exp_req   = 1'b0;
    exp_stall = 1'b0;
    exp_pcsrc = 1'b0;
    chk_bus   = 1'b0;
  endtask

  task automatic idleCycles(input int n, input logic ack_noise);
    setBubble();
    for (int i = 0; i < n; i++) begin
      dmem_ack   = ack_noise;
      dmem_rdata = $urandom;
      alu_result = $urandom;
      step();
    end
    dmem_ack = 1'b0;
  endtask

  task automatic clearObs();
    obs_req   = 0;
    obs_stall = 0;
    obs_pcsrc = 0;
    obs_flush = 0;
  endtask

  // One EX/MEM slot. With an access, the memory acks in REQ cycle ack_at.
  // ack_at = 0 means the memory never acks.
  task automatic applyStimulus(input logic rd, input logic wr, input logic br, input logic zr,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input int ack_at, input logic [31:0] rdata);
    logic acked;
    acked      = 1'b0;
    memread    = rd;
    memwrite   = wr;
    branch     = br;
    zero       = zr;
    alu_result = addr;
    rdata2out  = wd;
    dmem_ack   = 1'b0;
    exp_req    = 1'b0;
    chk_bus    = 1'b0;
    exp_stall  = rd | wr;
    exp_pcsrc  = br & zr & ~(rd | wr);
    step();
    if (rd | wr) begin
      exp_req   = 1'b1;
      chk_bus   = 1'b1;
      exp_we    = wr;
      exp_addr  = addr;
      exp_wdata = wd;
      exp_stall = 1'b1;
      exp_pcsrc = 1'b0;
      for (int c = 1; c <= MAX_WAIT && !acked; c++) begin
        dmem_ack   = (c == ack_at);
        dmem_rdata = (c == ack_at) ? rdata : $urandom;
        if (c == ack_at) acked = 1'b1;
        step();
      end
      dmem_ack  = 1'b0;
      exp_req   = 1'b0;
      chk_bus   = 1'b0;
      exp_stall = 1'b0;
      exp_pcsrc = br & zr;
      if (acked) begin
        if (!wr) exp_rd = rdata;
        chk_rd = 1'b1;
      end else begin
        chk_rd = 1'b0;
      end
      step();
      if (!acked) begin
        exp_rd  = 32'hDEADBEEF;
        exp_err = 1'b1;
        chk_rd  = 1'b1;
      end
    end
    setBubble();
  endtask

  // Per-cycle comparison against the expected values, plus the stall-count model.
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("dmem_req", {31'b0, dmem_req}, {31'b0, exp_req});
      checkOutput("stall", {31'b0, stall}, {31'b0, exp_stall});
      checkOutput("pcsrc", {31'b0, pcsrc}, {31'b0, exp_pcsrc});
      checkOutput("flush", {31'b0, flush}, {31'b0, exp_pcsrc});
      if (chk_bus) begin
        checkOutput("dmem_we", {31'b0, dmem_we}, {31'b0, exp_we});
        checkOutput("dmem_addr", dmem_addr, exp_addr);
        checkOutput("dmem_wdata", dmem_wdata, exp_wdata);
      end
      if (chk_rd) begin
        checkOutput("read_data", read_data, exp_rd);
        checkOutput("mem_err", {31'b0, mem_err}, {31'b0, exp_err});
      end
      checkOutput("stall_cycles", {{(32-CNT_W){1'b0}}, stall_cycles}, {{(32-CNT_W){1'b0}}, exp_sc});
      if (dmem_req === 1'b1) obs_req++;
      if (stall === 1'b1) obs_stall++;
      if (pcsrc === 1'b1) obs_pcsrc++;
      if (flush === 1'b1) obs_flush++;
    end
`ifdef MEM_STALL_CNT_EN
    if (!rst_n) exp_sc = '0;
    else if (exp_stall && (exp_sc != '1)) exp_sc = exp_sc + 1'b1;
`endif
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    branch     = 1'b0;
    zero       = 1'b0;
    dmem_ack   = $urandom_range(0, 1);
    alu_result = $urandom;
    rdata2out  = $urandom;
    dmem_rdata = $urandom;
    step();

    exp_rd     = '0;
    exp_err    = 1'b0;
    chk_bus    = 1'b1;
    chk_rd     = 1'b1;
    chk_en     = 1'b1;
    dmem_ack   = $urandom_range(0, 1);
    alu_result = $urandom;
    rdata2out  = $urandom;
    dmem_rdata = $urandom;
    step();
    rst_n = 1'b1;
    idleCycles(2, 1'b0);

    // Load: ack arrives in the third REQ cycle.
    clearObs();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 3, 32'h12345678);
    idleCycles(1, 1'b0);
    checkOutput("load_req_cycles", obs_req, 3);
    checkOutput("load_stall_cycles", obs_stall, 4);
    checkOutput("load_read_data", read_data, 32'h12345678);

    // Store: ack arrives in the first REQ cycle.
    clearObs();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h80, 32'hCAFEF00D, 1, 32'h0);
    idleCycles(1, 1'b0);
    checkOutput("store_req_cycles", obs_req, 1);
    checkOutput("store_stall_cycles", obs_stall, 2);
    checkOutput("store_keeps_read_data", read_data, 32'h12345678);
`ifdef MEM_STALL_CNT_EN
    checkOutput("stall_cnt_after_load_store", {16'b0, stall_cycles}, 6);
`else
    checkOutput("stall_cnt_disabled", {16'b0, stall_cycles}, 0);
`endif

    // An ack arriving outside REQ must be ignored.
    clearObs();
    idleCycles(3, 1'b1);
    checkOutput("stray_ack_req", obs_req, 0);
    checkOutput("stray_ack_read_data", read_data, 32'h12345678);

    // Read and write together behave as a write.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h55AA55AA, 2, 32'hFFFF0000);
    idleCycles(1, 1'b0);
    checkOutput("rdwr_keeps_read_data", read_data, 32'h12345678);

    // Branch without an access, branch not taken, and branch sharing a slot with a load.
    clearObs();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 0, 32'h0);
    checkOutput("branch_taken_pcsrc", obs_pcsrc, 1);
    checkOutput("branch_taken_flush", obs_flush, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 0, 32'h0);
    checkOutput("branch_not_taken_pcsrc", obs_pcsrc, 1);
    clearObs();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h44, 32'h0, 2, 32'h0BADF00D);
    idleCycles(1, 1'b0);
    checkOutput("branch_with_load_pcsrc", obs_pcsrc, 1);
    checkOutput("branch_with_load_stall", obs_stall, 3);

    // Timeout: the memory never acks.
    clearObs();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h200, 32'h0, 0, 32'h0);
    idleCycles(1, 1'b0);
    checkOutput("timeout_req_cycles", obs_req, 15);
    checkOutput("timeout_stall_cycles", obs_stall, 16);
    checkOutput("timeout_read_data", read_data, 32'hDEADBEEF);
    checkOutput("timeout_mem_err", {31'b0, mem_err}, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h204, 32'h0, 1, 32'hA5A5A5A5);
    idleCycles(1, 1'b0);
    checkOutput("mem_err_sticky", {31'b0, mem_err}, 1);
    checkOutput("after_err_read_data", read_data, 32'hA5A5A5A5);

    // Reset asserted during the second REQ cycle aborts the access.
    memread    = 1'b1;
    alu_result = 32'h300;
    rdata2out  = 32'h0;
    exp_stall  = 1'b1;
    exp_pcsrc  = 1'b0;
    step();
    exp_req   = 1'b1;
    chk_bus   = 1'b1;
    exp_we    = 1'b0;
    exp_addr  = 32'h300;
    exp_wdata = 32'h0;
    step();
    rst_n   = 1'b0;
    memread = 1'b0;
    step();
    exp_req   = 1'b0;
    exp_stall = 1'b0;
    exp_we    = 1'b0;
    exp_addr  = '0;
    exp_wdata = '0;
    exp_rd    = '0;
    exp_err   = 1'b0;
    @(negedge clk);
    checkOutput("reset_abort_req", {31'b0, dmem_req}, 0);
    checkOutput("reset_abort_err", {31'b0, mem_err}, 0);
    step();
    rst_n = 1'b1;
    idleCycles(2, 1'b0);

    // A normal store still works after the aborted access.
    clearObs();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h3C0, 32'h13572468, 4, 32'h0);
    idleCycles(2, 1'b0);
    checkOutput("post_reset_store_stall", obs_stall, 5);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
